// File: rtl/mcpu_ctrl.sv
// ============================================================================
//  Module      : mcpu_ctrl
//  Description : Main control FSM of a multi-cycle MIPS CPU with memory-wait
//                timeout, debug state export and retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       ir_op,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             mem_err,
    output logic             illegal_op
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REX  = 4'd6,
        S_RWB  = 4'd7,
        S_BR   = 4'd8,
        S_JMP  = 4'd9,
        S_IEX  = 4'd10,
        S_IWB  = 4'd11,
        S_HALT = 4'd15
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_HALT  = 6'b111111;
    localparam logic [7:0] c_WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_waiting;
    logic             w_abort;
    logic             w_retire;
    logic             w_illegal;

    assign w_waiting = ((r_state == S_IF) || (r_state == S_MRD) || (r_state == S_MWR))
                       && !mem_ready;
    assign w_abort   = w_waiting && (r_wait_cnt == c_WAIT_LAST);

    always_comb begin
        w_next    = S_IF;
        w_illegal = 1'b0;
        case (r_state)
            S_IF:   w_next = mem_ready ? S_ID : S_IF;
            S_ID: begin
                case (ir_op)
                    c_OP_RTYPE:                    w_next = S_REX;
                    c_OP_LW, c_OP_SW:              w_next = S_MADR;
                    c_OP_BEQ, c_OP_BNE:            w_next = S_BR;
                    c_OP_J:                        w_next = S_JMP;
                    c_OP_ADDI, c_OP_ANDI,
                    c_OP_ORI, c_OP_SLTI:           w_next = S_IEX;
                    c_OP_HALT:                     w_next = S_HALT;
                    default: begin
                        w_next    = S_IF;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MADR: w_next = (ir_op == c_OP_SW) ? S_MWR : S_MRD;
            S_MRD:  w_next = mem_ready ? S_MWB : (w_abort ? S_IF : S_MRD);
            S_MWB:  w_next = S_IF;
            S_MWR:  w_next = (mem_ready || w_abort) ? S_IF : S_MWR;
            S_REX:  w_next = S_RWB;
            S_RWB:  w_next = S_IF;
            S_BR:   w_next = S_IF;
            S_JMP:  w_next = S_IF;
            S_IEX:  w_next = S_IWB;
            S_IWB:  w_next = S_IF;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IF;
        endcase
    end

    always_comb begin
        case (r_state)
            S_MWB, S_RWB, S_BR, S_JMP, S_IWB: w_retire = 1'b1;
            S_MWR:  w_retire = mem_ready;
            S_ID:   w_retire = (ir_op == c_OP_HALT);
            default: w_retire = 1'b0;
        endcase
    end

    // An abort in IF leaves the state unchanged, so the counter clears on abort explicitly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IF;
            r_wait_cnt <= 8'd0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            if (w_waiting && !w_abort && (w_next == r_state))
                r_wait_cnt <= r_wait_cnt + 8'd1;
            else
                r_wait_cnt <= 8'd0;
            if (w_retire)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        case (r_state)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_ID:   alu_src_b = 2'b11;
            S_MADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MWR: begin
                iord      = 1'b1;
                mem_write = !w_abort;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BR: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = (ir_op == c_OP_BNE);
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_IWB:  reg_write = 1'b1;
            default: ;
        endcase
        // Reset is asynchronous, so strobes must be masked combinationally too.
        if (!rst) begin
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
        end
    end

    assign state_out  = r_state;
    assign instr_cnt  = r_cnt;
    assign mem_err    = w_abort && rst;
    assign illegal_op = w_illegal && rst;

endmodule

`default_nettype wire

// File: tb/tb_mcpu_ctrl.sv
// ============================================================================
//  Module      : tb_mcpu_ctrl
//  Description : Directed scoreboard bench for mcpu_ctrl (per-cycle expected
//                state, count and control word queued by the driver).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcpu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  ir_op = 6'd0;
    logic        mem_ready = 1'b0;
    logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic        alu_src_a, reg_dst, mem_to_reg, reg_write, mem_err, illegal_op;
    logic [3:0]  state_out;
    logic [31:0] instr_cnt;

    mcpu_ctrl #(.WAIT_MAX(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ir_op(ir_op), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .state_out(state_out), .instr_cnt(instr_cnt),
        .mem_err(mem_err), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Control word bit layout, MSB first.
    localparam logic [18:0] B_MRD  = 19'd1 << 18;
    localparam logic [18:0] B_MWR  = 19'd1 << 17;
    localparam logic [18:0] B_IORD = 19'd1 << 16;
    localparam logic [18:0] B_IRW  = 19'd1 << 15;
    localparam logic [18:0] B_PCW  = 19'd1 << 14;
    localparam logic [18:0] B_PCWC = 19'd1 << 13;
    localparam logic [18:0] B_BNE  = 19'd1 << 12;
    localparam logic [18:0] PCS_AO = 19'd1 << 10;
    localparam logic [18:0] PCS_J  = 19'd2 << 10;
    localparam logic [18:0] B_SRCA = 19'd1 << 9;
    localparam logic [18:0] SB_4   = 19'd1 << 7;
    localparam logic [18:0] SB_IMM = 19'd2 << 7;
    localparam logic [18:0] SB_SH2 = 19'd3 << 7;
    localparam logic [18:0] AO_SUB = 19'd1 << 5;
    localparam logic [18:0] AO_FN  = 19'd2 << 5;
    localparam logic [18:0] AO_IMM = 19'd3 << 5;
    localparam logic [18:0] B_RDST = 19'd1 << 4;
    localparam logic [18:0] B_M2R  = 19'd1 << 3;
    localparam logic [18:0] B_RW   = 19'd1 << 2;
    localparam logic [18:0] B_MERR = 19'd1 << 1;
    localparam logic [18:0] B_ILL  = 19'd1;

    localparam logic [18:0] K_IFW  = B_MRD | SB_4;
    localparam logic [18:0] K_IFR  = K_IFW | B_IRW | B_PCW;
    localparam logic [18:0] K_ID   = SB_SH2;
    localparam logic [18:0] K_MADR = B_SRCA | SB_IMM;
    localparam logic [18:0] K_MRD  = B_IORD | B_MRD;
    localparam logic [18:0] K_MWB  = B_M2R | B_RW;
    localparam logic [18:0] K_MWR  = B_IORD | B_MWR;
    localparam logic [18:0] K_REX  = B_SRCA | AO_FN;
    localparam logic [18:0] K_RWB  = B_RDST | B_RW;
    localparam logic [18:0] K_BEQ  = B_SRCA | AO_SUB | B_PCWC | PCS_AO;
    localparam logic [18:0] K_BNE  = K_BEQ | B_BNE;
    localparam logic [18:0] K_JMP  = B_PCW | PCS_J;
    localparam logic [18:0] K_IEX  = B_SRCA | SB_IMM | AO_IMM;
    localparam logic [18:0] K_IWB  = B_RW;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_HALT = 6'b111111, OP_BAD = 6'b111110;

    logic [54:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_err = 0;

    wire [18:0] w_ctl = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                         branch_ne, pc_source, alu_src_a, alu_src_b, alu_op, reg_dst,
                         mem_to_reg, reg_write, mem_err, illegal_op};

    task automatic step(input logic r, input logic rdy, input logic [5:0] op,
                        input logic [3:0] st, input int unsigned cnt,
                        input logic [18:0] ctl, input string nm);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        ir_op     = op;
        exp_q.push_back({st, 32'(cnt), ctl});
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [54:0] e;
        logic [54:0] a;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {state_out, instr_cnt, w_ctl};
                n_checks++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL %s: got st=%0d cnt=%0d ctl=%05h, want st=%0d cnt=%0d ctl=%05h",
                             nm, a[54:51], a[50:19], a[18:0], e[54:51], e[50:19], e[18:0]);
                end
            end
        end
    end

    initial begin : driver
        step(0, 0, OP_R, 0, 0, K_IFW, "reset_idle");
        step(0, 1, OP_R, 0, 0, K_IFW, "reset_strobes_masked");
        // R-type, memory always ready
        step(1, 1, OP_R, 0, 0, K_IFR, "r_if");
        step(1, 1, OP_R, 1, 0, K_ID,  "r_id");
        step(1, 1, OP_R, 6, 0, K_REX, "r_rex");
        step(1, 1, OP_R, 7, 0, K_RWB, "r_rwb");
        // lw with three not-ready cycles in MRD
        step(1, 1, OP_LW, 0, 1, K_IFR,  "lw_if");
        step(1, 1, OP_LW, 1, 1, K_ID,   "lw_id");
        step(1, 0, OP_LW, 2, 1, K_MADR, "lw_madr");
        step(1, 0, OP_LW, 3, 1, K_MRD,  "lw_mrd0");
        step(1, 0, OP_LW, 3, 1, K_MRD,  "lw_mrd1");
        step(1, 0, OP_LW, 3, 1, K_MRD,  "lw_mrd2");
        step(1, 1, OP_LW, 3, 1, K_MRD,  "lw_mrd3");
        step(1, 1, OP_LW, 4, 1, K_MWB,  "lw_mwb");
        // beq then bne
        step(1, 1, OP_BEQ, 0, 2, K_IFR, "beq_if");
        step(1, 1, OP_BEQ, 1, 2, K_ID,  "beq_id");
        step(1, 1, OP_BEQ, 8, 2, K_BEQ, "beq_br");
        step(1, 1, OP_BNE, 0, 3, K_IFR, "bne_if");
        step(1, 1, OP_BNE, 1, 3, K_ID,  "bne_id");
        step(1, 1, OP_BNE, 8, 3, K_BNE, "bne_br");
        // sw: ready arrives exactly on the timeout cycle, so it completes
        step(1, 1, OP_SW, 0, 4, K_IFR,  "sw_if");
        step(1, 1, OP_SW, 1, 4, K_ID,   "sw_id");
        step(1, 0, OP_SW, 2, 4, K_MADR, "sw_madr");
        step(1, 0, OP_SW, 5, 4, K_MWR,  "sw_mwr0");
        step(1, 0, OP_SW, 5, 4, K_MWR,  "sw_mwr1");
        step(1, 0, OP_SW, 5, 4, K_MWR,  "sw_mwr2");
        step(1, 1, OP_SW, 5, 4, K_MWR,  "sw_mwr_ready_wins");
        // sw aborted in MWR: no write strobe, no retire
        step(1, 1, OP_SW, 0, 5, K_IFR,  "swab_if");
        step(1, 1, OP_SW, 1, 5, K_ID,   "swab_id");
        step(1, 0, OP_SW, 2, 5, K_MADR, "swab_madr");
        step(1, 0, OP_SW, 5, 5, K_MWR,  "swab_mwr0");
        step(1, 0, OP_SW, 5, 5, K_MWR,  "swab_mwr1");
        step(1, 0, OP_SW, 5, 5, K_MWR,  "swab_mwr2");
        step(1, 0, OP_SW, 5, 5, B_IORD | B_MERR, "swab_abort");
        // jump, then addi
        step(1, 1, OP_J, 0, 5, K_IFR, "j_if");
        step(1, 1, OP_J, 1, 5, K_ID,  "j_id");
        step(1, 1, OP_J, 9, 5, K_JMP, "j_jmp");
        step(1, 1, OP_ADDI, 0, 6,  K_IFR, "addi_if");
        step(1, 1, OP_ADDI, 1, 6,  K_ID,  "addi_id");
        step(1, 1, OP_ADDI, 10, 6, K_IEX, "addi_iex");
        step(1, 1, OP_ADDI, 11, 6, K_IWB, "addi_iwb");
        // fetch timeout, then retry, then illegal opcode
        step(1, 0, OP_BAD, 0, 7, K_IFW, "ifto_0");
        step(1, 0, OP_BAD, 0, 7, K_IFW, "ifto_1");
        step(1, 0, OP_BAD, 0, 7, K_IFW, "ifto_2");
        step(1, 0, OP_BAD, 0, 7, K_IFW | B_MERR, "ifto_abort");
        step(1, 1, OP_BAD, 0, 7, K_IFR, "ifto_retry");
        step(1, 1, OP_BAD, 1, 7, K_ID | B_ILL, "illegal_id");
        // halt
        step(1, 1, OP_HALT, 0, 7, K_IFR, "halt_if");
        step(1, 1, OP_HALT, 1, 7, K_ID,  "halt_id");
        step(1, 1, OP_HALT, 15, 8, 19'd0, "halt_0");
        step(1, 0, OP_HALT, 15, 8, 19'd0, "halt_1");
        // reset asserted mid-store
        step(0, 0, OP_SW, 0, 0, K_IFW, "rst_from_halt");
        step(1, 1, OP_SW, 0, 0, K_IFR,  "rsw_if");
        step(1, 1, OP_SW, 1, 0, K_ID,   "rsw_id");
        step(1, 0, OP_SW, 2, 0, K_MADR, "rsw_madr");
        step(1, 0, OP_SW, 5, 0, K_MWR,  "rsw_mwr");
        step(0, 1, OP_SW, 0, 0, K_IFW,  "rsw_async_reset");
        step(0, 1, OP_SW, 0, 0, K_IFW,  "rsw_reset_hold");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
